// File: rtl/alu_seq_exec.sv
// alu_seq_exec: single-issue ALU. Logic, arithmetic and compare ops finish in one cycle;
// shifts by a nonzero amount run serially, one bit per cycle, while busy is high.

`ifndef AND_CONTROL
`define AND_CONTROL  5'd0
`define OR_CONTROL   5'd1
`define XOR_CONTROL  5'd2
`define NOR_CONTROL  5'd3
`define ADD_CONTROL  5'd4
`define ADDU_CONTROL 5'd5
`define SUB_CONTROL  5'd6
`define SUBU_CONTROL 5'd7
`define SLL_CONTROL  5'd8
`define SRL_CONTROL  5'd9
`define SRA_CONTROL  5'd10
`define SLLV_CONTROL 5'd11
`define SRLV_CONTROL 5'd12
`define SRAV_CONTROL 5'd13
`define SLT_CONTROL  5'd14
`define SLTU_CONTROL 5'd15
`define LUI_CONTROL  5'd16
`define LOSE_CONTROL 5'd31
`endif

module alu_seq_exec #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       sa,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             invalid_op
);

    typedef enum logic {StIdle, StShift} state_e;
    typedef enum logic [1:0] {DirLeft, DirRightLogic, DirRightArith} dir_e;

    state_e           state_q, state_d;
    dir_e             dir_q, dir_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             inv_q, inv_d;

    logic             is_shift;
    dir_e             op_dir;
    logic [4:0]       op_amt;
    logic [WIDTH-1:0] comb_res;
    logic             comb_ovf;
    logic             comb_inv;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] shifted;

    // Single-cycle result for the op presented on the inputs; shifts only decode here.
    always_comb begin
        sum      = a + b;
        diff     = a - b;
        comb_res = '0;
        comb_ovf = 1'b0;
        comb_inv = 1'b0;
        is_shift = 1'b0;
        op_dir   = DirLeft;
        op_amt   = sa;
        case (alu_control)
            `AND_CONTROL:  comb_res = a & b;
            `OR_CONTROL:   comb_res = a | b;
            `XOR_CONTROL:  comb_res = a ^ b;
            `NOR_CONTROL:  comb_res = ~(a | b);
            `ADD_CONTROL: begin
                comb_res = sum;
                comb_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            `ADDU_CONTROL: comb_res = sum;
            `SUB_CONTROL: begin
                comb_res = diff;
                comb_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            `SUBU_CONTROL: comb_res = diff;
            `SLT_CONTROL:  comb_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            `SLTU_CONTROL: comb_res = {{(WIDTH-1){1'b0}}, a < b};
            `LUI_CONTROL:  comb_res = {b[15:0], {(WIDTH-16){1'b0}}};
            `SLL_CONTROL: begin
                is_shift = 1'b1;
                op_dir   = DirLeft;
            end
            `SRL_CONTROL: begin
                is_shift = 1'b1;
                op_dir   = DirRightLogic;
            end
            `SRA_CONTROL: begin
                is_shift = 1'b1;
                op_dir   = DirRightArith;
            end
            `SLLV_CONTROL: begin
                is_shift = 1'b1;
                op_dir   = DirLeft;
                op_amt   = a[4:0];
            end
            `SRLV_CONTROL: begin
                is_shift = 1'b1;
                op_dir   = DirRightLogic;
                op_amt   = a[4:0];
            end
            `SRAV_CONTROL: begin
                is_shift = 1'b1;
                op_dir   = DirRightArith;
                op_amt   = a[4:0];
            end
            `LOSE_CONTROL: comb_inv = 1'b1;
            default:       comb_inv = 1'b1;
        endcase
        // A zero-length shift returns b unchanged without entering the shift state.
        if (is_shift) begin
            comb_res = b;
        end
    end

    always_comb begin
        case (dir_q)
            DirLeft:       shifted = {val_q[WIDTH-2:0], 1'b0};
            DirRightLogic: shifted = {1'b0, val_q[WIDTH-1:1]};
            default:       shifted = {val_q[WIDTH-1], val_q[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        val_d    = val_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        inv_d    = inv_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (is_shift && (op_amt != 5'd0)) begin
                        state_d = StShift;
                        val_d   = b;
                        cnt_d   = op_amt;
                        dir_d   = op_dir;
                    end else begin
                        result_d = comb_res;
                        ovf_d    = comb_ovf;
                        inv_d    = comb_inv;
                        done_d   = 1'b1;
                    end
                end
            end
            StShift: begin
                val_d = shifted;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    result_d = shifted;
                    ovf_d    = 1'b0;
                    inv_d    = 1'b0;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            dir_q    <= DirLeft;
            val_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            val_q    <= val_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            inv_q    <= inv_d;
        end
    end

    assign busy       = (state_q == StShift);
    assign done       = done_q;
    assign result     = result_q;
    assign overflow   = ovf_q;
    assign invalid_op = inv_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Randomised bench for alu_seq_exec: a behavioural model predicts result, flags and
// completion latency of every accepted op; outputs are sampled on the falling edge.

`ifndef AND_CONTROL
`define AND_CONTROL  5'd0
`define OR_CONTROL   5'd1
`define XOR_CONTROL  5'd2
`define NOR_CONTROL  5'd3
`define ADD_CONTROL  5'd4
`define ADDU_CONTROL 5'd5
`define SUB_CONTROL  5'd6
`define SUBU_CONTROL 5'd7
`define SLL_CONTROL  5'd8
`define SRL_CONTROL  5'd9
`define SRA_CONTROL  5'd10
`define SLLV_CONTROL 5'd11
`define SRLV_CONTROL 5'd12
`define SRAV_CONTROL 5'd13
`define SLT_CONTROL  5'd14
`define SLTU_CONTROL 5'd15
`define LUI_CONTROL  5'd16
`define LOSE_CONTROL 5'd31
`endif

module tb_alu_seq_exec;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  alu_control;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sa;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow;
    logic        invalid_op;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] prev_res = '0;
    logic        prev_ovf = 1'b0;
    logic        prev_inv = 1'b0;

    alu_seq_exec #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .alu_control(alu_control),
        .a          (a),
        .b          (b),
        .sa         (sa),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .overflow   (overflow),
        .invalid_op (invalid_op)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: full-width arithmetic, whole-word shifts, latency from the shift amount.
    function automatic void model(input logic [4:0] op, input logic [31:0] ra,
                                  input logic [31:0] rb, input logic [4:0] rsa,
                                  output logic [31:0] res, output logic ovf,
                                  output logic inv, output int lat);
        longint s;
        int     k;
        res = '0;
        ovf = 1'b0;
        inv = 1'b0;
        lat = 1;
        k   = 0;
        case (op)
            `AND_CONTROL:  res = ra & rb;
            `OR_CONTROL:   res = ra | rb;
            `XOR_CONTROL:  res = ra ^ rb;
            `NOR_CONTROL:  res = ~(ra | rb);
            `ADD_CONTROL: begin
                res = ra + rb;
                s   = longint'($signed(ra)) + longint'($signed(rb));
                ovf = (s != longint'($signed(res)));
            end
            `ADDU_CONTROL: res = ra + rb;
            `SUB_CONTROL: begin
                res = ra - rb;
                s   = longint'($signed(ra)) - longint'($signed(rb));
                ovf = (s != longint'($signed(res)));
            end
            `SUBU_CONTROL: res = ra - rb;
            `SLT_CONTROL:  res = ($signed(ra) < $signed(rb)) ? 32'd1 : 32'd0;
            `SLTU_CONTROL: res = (ra < rb) ? 32'd1 : 32'd0;
            `LUI_CONTROL:  res = rb << 16;
            `SLL_CONTROL, `SLLV_CONTROL: begin
                k   = (op == `SLL_CONTROL) ? int'(rsa) : int'(ra[4:0]);
                res = rb << k;
            end
            `SRL_CONTROL, `SRLV_CONTROL: begin
                k   = (op == `SRL_CONTROL) ? int'(rsa) : int'(ra[4:0]);
                res = rb >> k;
            end
            `SRA_CONTROL, `SRAV_CONTROL: begin
                k   = (op == `SRA_CONTROL) ? int'(rsa) : int'(ra[4:0]);
                res = $signed(rb) >>> k;
            end
            default: inv = 1'b1;
        endcase
        lat = (k == 0) ? 1 : k + 1;
    endfunction

    // Called at a falling edge with the DUT idle; returns at the falling edge after done,
    // so consecutive calls issue back-to-back starts.
    task automatic run_op(input logic [4:0] op, input logic [31:0] ra, input logic [31:0] rb,
                          input logic [4:0] rsa, input bit noise);
        logic [31:0] exp_res;
        logic        exp_ovf;
        logic        exp_inv;
        int          lat;
        model(op, ra, rb, rsa, exp_res, exp_ovf, exp_inv, lat);
        start       = 1'b1;
        alu_control = op;
        a           = ra;
        b           = rb;
        sa          = rsa;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            start       = noise && (c < lat);
            alu_control = 5'($urandom_range(0, 31));
            a           = $urandom;
            b           = $urandom;
            sa          = 5'($urandom);
            check_eq("done", {31'd0, done}, {31'd0, c == lat});
            check_eq("busy", {31'd0, busy}, {31'd0, c < lat});
            if (c == lat) begin
                check_eq("result", result, exp_res);
                check_eq("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
                check_eq("invalid_op", {31'd0, invalid_op}, {31'd0, exp_inv});
            end else begin
                check_eq("result_held", result, prev_res);
                check_eq("flags_held", {30'd0, overflow, invalid_op},
                         {30'd0, prev_ovf, prev_inv});
            end
        end
        start    = 1'b0;
        prev_res = exp_res;
        prev_ovf = exp_ovf;
        prev_inv = exp_inv;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {busy, done, overflow, invalid_op, 28'd0}, 32'd0);
        check_eq({tag, "_result"}, result, 32'd0);
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  rsa;
        rst         = 1'b1;
        start       = 1'b0;
        alu_control = '0;
        a           = '0;
        b           = '0;
        sa          = '0;
        @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        run_op(`ADD_CONTROL, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b0);
        run_op(`ADDU_CONTROL, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b0);
        run_op(`SUB_CONTROL, 32'h8000_0000, 32'd1, 5'd0, 1'b0);
        run_op(`SRA_CONTROL, 32'd0, 32'h8000_0000, 5'd4, 1'b0);
        run_op(`SLLV_CONTROL, 32'd0, 32'h1234_5678, 5'd7, 1'b0);
        run_op(`SLT_CONTROL, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
        run_op(`SLTU_CONTROL, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
        run_op(`SRL_CONTROL, 32'h1234_5678, 32'h8000_0000, 5'd31, 1'b1);
        run_op(`LUI_CONTROL, 32'h5555_5555, 32'h0000_ABCD, 5'd0, 1'b0);
        run_op(`LOSE_CONTROL, 32'h1, 32'h2, 5'd3, 1'b0);

        // Reset three cycles into a 10-bit shift: immediate clear and no late done.
        start       = 1'b1;
        alu_control = `SLL_CONTROL;
        b           = 32'h0000_0F0F;
        sa          = 5'd10;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        check_all_zero("reset_hold");
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_eq("no_done_after_abort", {busy, done, 30'd0}, 32'd0);
        end
        prev_res = '0;
        prev_ovf = 1'b0;
        prev_inv = 1'b0;
        run_op(5'd20, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                op = 5'($urandom_range(0, 31));
            end else begin
                op = 5'($urandom_range(0, 16));
            end
            ra  = $urandom;
            rb  = $urandom;
            rsa = 5'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                rsa     = 5'd0;
                ra[4:0] = 5'd0;
            end
            run_op(op, ra, rb, rsa, bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                check_eq("idle_gap", {31'd0, done}, 32'd0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_exec.md
ALU_SEQ_EXEC -- requirements
Module: alu_seq_exec

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; only 32 is supported.
REQ-002 SHALL take operation codes from the shared defines header macros AND_CONTROL … SLTU_CONTROL, LUI_CONTROL and LOSE_CONTROL.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  request; sampled only when busy=0.
REQ-006 alu_control  input  5  operation code; sampled with start.
REQ-007 a  input  WIDTH  operand rs; shift-amount source for SLLV/SRLV/SRAV via a[4:0].
REQ-008 b  input  WIDTH  operand rt; value shifted for all shifts; LUI source.
REQ-009 sa  input  5  shift amount for SLL/SRL/SRA.
REQ-010 busy  output  1  high while a serial shift is in progress.
REQ-011 done  output  1  one-cycle pulse, result valid.
REQ-012 result  output  WIDTH  registered result; held until the next done.
REQ-013 overflow  output  1  signed overflow flag for ADD/SUB; updated with done.
REQ-014 invalid_op  output  1  unrecognised or LOSE_CONTROL code; updated with done.

Function
REQ-015 SHALL implement a two-state FSM: IDLE (busy=0) and SHIFT (busy=1).
REQ-016 IDLE + start with a non-shift code SHALL capture the result at the next edge and pulse done that cycle, giving 1-cycle latency.
REQ-017 Non-shift ops: AND/OR/XOR/NOR bitwise on a,b; ADD/ADDU = a+b; SUB/SUBU = a-b mod 2^32.
REQ-018 Non-shift ops: SLT = signed a<b ? 1 : 0; SLTU = unsigned compare, same output encoding; LUI = {b[15:0],16'h0000}.
REQ-019 overflow SHALL be 1 only for ADD/SUB with signed overflow; 0 for every other op, including ADDU/SUBU.
REQ-020 Unrecognised codes and LOSE_CONTROL SHALL give result=0, invalid_op=1, overflow=0, with 1-cycle latency.
REQ-021 Shift start with amount k=0 SHALL behave as a non-shift op: result=b, done at N+1, SHIFT never entered.
REQ-022 Shift start with k>0 SHALL load b and k, then enter SHIFT; each SHIFT cycle moves the value 1 bit and decrements the counter.
REQ-023 In SHIFT, SLL variants shift left with zero fill, SRL variants shift right with zero fill, and SRA variants shift right replicating bit 31.
REQ-024 A k>0 shift SHALL pulse done at edge N+1+k and return to IDLE on that edge.
REQ-025 start while busy=1 SHALL be ignored: no capture, no effect on the op in flight.
REQ-026 start in the cycle done is high (state IDLE) SHALL be accepted normally, so back-to-back ops run without a gap.
REQ-027 Operand changes after acceptance SHALL NOT affect the result.
REQ-028 result, overflow and invalid_op SHALL change only on the edge that asserts done.

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE with busy=0, done=0, result=0, overflow=0, invalid_op=0 and the shift counter cleared.
REQ-030 rst asserted mid-shift SHALL abort the op with no done pulse; after release, the first start behaves as from power-up.

Verification
REQ-031 ADD, a=32'h7FFF_FFFF, b=1 -> done at N+1, result=32'h8000_0000, overflow=1; same with ADDU -> overflow=0.
REQ-032 SRA, b=32'h8000_0000, sa=4 -> busy for 4 cycles, done at N+5, result=32'hF800_0000.
REQ-033 SLLV, a=32'h0000_0000, b=32'h1234_5678 -> done at N+1, result=32'h1234_5678, busy never high.
REQ-034 SLT, a=32'hFFFF_FFFF, b=1 -> result=1; SLTU, same operands -> result=0.
REQ-035 SRL, sa=31, b=32'h8000_0000, with extra starts pulsed during busy -> only one done at N+32, result=1; a start in the done cycle (LUI, b=16'hABCD) -> result=32'hABCD_0000 at the next edge.
REQ-036 rst pulsed after 3 cycles of an SLL by 10 -> all outputs 0 immediately and no done; invalid code afterwards -> result=0, invalid_op=1.
